// File: rtl/uart_fifo_tx_drain_if.sv
// FIFO read-side port of the UART drain: the drain is the master issuing read
// strobes, the FIFO is the slave answering with empty flag and data.
interface uart_fifo_tx_drain_if;
  logic       fifo_rd_en;
  logic       fifo_rd_empty;
  logic [7:0] fifo_rd_data;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_empty,
    input  fifo_rd_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_empty,
    output fifo_rd_data
  );
endinterface

// File: rtl/uart_fifo_tx_drain.sv
// Drains bytes from a FIFO and serialises each as an 8N1/8N2 UART frame,
// LSB first, with a registered glitch-free serial output.
module uart_fifo_tx_drain #(
  parameter int c_CLK_DIV    = 434,
  parameter int c_RD_LATENCY = 1,
  parameter int c_STOP_BITS  = 1
) (
  input  logic                        rd_clk,
  input  logic                        rd_rst,
  input  logic                        tx_enable,
  uart_fifo_tx_drain_if.master        fifo,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic                        tx_done
);

  localparam int                BAUD_W    = $clog2(c_CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(c_CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(c_CLK_DIV - 2);
  localparam logic              WAIT_LAST = 1'(c_RD_LATENCY - 1);
  localparam logic              STOP_LAST = 1'(c_STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic              wait_cnt;
  logic              stop_cnt;
  logic [7:0]        shreg;
  logic              rd_go;

  // Read strobe is combinational so the FIFO sees it in the same cycle the
  // request condition holds; reset masks it unconditionally.
  always_comb begin
    rd_go = !rd_rst && (state == IDLE) && tx_enable && !fifo.fifo_rd_empty;
  end

  always_comb begin
    fifo.fifo_rd_en = rd_go;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      stop_cnt <= '0;
      shreg    <= '0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_go) begin
            state    <= WAIT;
            wait_cnt <= '0;
            baud_cnt <= '0;
            tx_busy  <= 1'b1;
          end
        end

        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            shreg    <= fifo.fifo_rd_data;
            state    <= START;
            baud_cnt <= '0;
            uart_txd <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_txd <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state    <= STOP;
              stop_cnt <= '0;
              uart_txd <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              uart_txd <= shreg[0];
              shreg    <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          // Registered done: raise it one cycle early so it lands on the last stop cycle.
          if ((baud_cnt == BAUD_PRE) && (stop_cnt == STOP_LAST)) begin
            tx_done <= 1'b1;
          end
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          uart_txd <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_fifo_tx_drain.md
UART_FIFO_TX_DRAIN -- requirements
Module: uart_fifo_tx_drain

Interface
REQ-001 Parameter c_CLK_DIV, default 434, SHALL set rd_clk cycles per UART bit; legal range 2..65535.
REQ-002 Parameter c_RD_LATENCY, default 1, SHALL set FIFO read latency in cycles from fifo_rd_en to valid fifo_rd_data; legal values 1 or 2.
REQ-003 Parameter c_STOP_BITS, default 1, SHALL set the number of stop bits per frame; legal values 1 or 2.
REQ-004 rd_clk  input  1  SHALL be the only clock; all logic is rising-edge.
REQ-005 rd_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 tx_enable  input  1  SHALL permit the start of new frames while high.
REQ-007 fifo_rd_empty  input  1  SHALL be the FIFO empty flag.
REQ-008 fifo_rd_data  input  8  SHALL be the FIFO read data.
REQ-009 fifo_rd_en  output  1  SHALL be the FIFO read enable (one-cycle pulse per byte).
REQ-010 uart_txd  output  1  SHALL be the serial line: 8N1, or 8N2 per c_STOP_BITS; idle high.
REQ-011 tx_busy  output  1  SHALL be high in every state except IDLE.
REQ-012 tx_done  output  1  SHALL be a one-cycle pulse marking frame completion.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, START, DATA, STOP.
REQ-014 IDLE: when tx_enable=1 and fifo_rd_empty=0 in cycle T, fifo_rd_en SHALL be 1 in cycle T and the FSM SHALL enter WAIT at T+1; otherwise stay in IDLE with fifo_rd_en=0.
REQ-015 fifo_rd_en SHALL never assert outside IDLE or while fifo_rd_empty=1.
REQ-016 WAIT SHALL last exactly c_RD_LATENCY cycles (T+1..T+c_RD_LATENCY).
REQ-017 In the last WAIT cycle, fifo_rd_data SHALL be captured into an 8-bit shift register; START begins at cycle T+c_RD_LATENCY+1.
REQ-018 START SHALL drive uart_txd=0 for c_CLK_DIV cycles.
REQ-019 DATA SHALL send bits 0..7, LSB first, each for c_CLK_DIV cycles; a 3-bit bit counter tracks position.
REQ-020 STOP SHALL drive uart_txd=1 for c_STOP_BITS*c_CLK_DIV cycles.
REQ-021 tx_done SHALL be 1 in the final STOP cycle only; the next cycle is IDLE.
REQ-022 Baud counter SHALL be ceil(log2(c_CLK_DIV)) bits, count 0..c_CLK_DIV-1, and reload to 0 on every state entry.
REQ-023 uart_txd SHALL be registered and glitch-free; it SHALL be 1 in IDLE and WAIT.
REQ-024 Back-to-back frames: idle-high gap between the last stop cycle and the next start bit SHALL be exactly 1+c_RD_LATENCY cycles.
REQ-025 tx_enable falling mid-frame SHALL NOT abort the frame; it only blocks the next IDLE read.
REQ-026 fifo_rd_data SHALL be ignored outside the capture cycle; changes in fifo_rd_empty after the read SHALL NOT affect the frame.

Reset
REQ-027 While rd_rst=1 at a clock edge: state=IDLE, uart_txd=1, fifo_rd_en=0, tx_busy=0, tx_done=0, counters=0, shift register=0x00.
REQ-028 Reset mid-frame SHALL abort the frame. uart_txd SHALL be 1 from the first edge with rd_rst=1. The partially sent byte SHALL NOT be resent.
REQ-029 fifo_rd_en SHALL be 0 in any cycle where rd_rst=1.

Verification (c_CLK_DIV=4, c_RD_LATENCY=1, c_STOP_BITS=1 unless noted)
REQ-030 FIFO holds 0x55, tx_enable=1 -> one fifo_rd_en pulse. uart_txd = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. tx_done pulses once. tx_busy is high for 41 cycles.
REQ-031 fifo_rd_empty=1, tx_enable=1 for 200 cycles -> fifo_rd_en never asserts, uart_txd stays 1, tx_busy stays 0.
REQ-032 FIFO holds 0xA3 then 0x0F -> two frames, LSB first. Gap between stop end and second start = 2 cycles (3 with c_RD_LATENCY=2). Exactly 2 fifo_rd_en pulses.
REQ-033 rd_rst pulsed for 1 cycle during bit 3 of 0xFF -> uart_txd=1 and tx_busy=0 after that edge. No tx_done. The next frame carries the next FIFO byte.
REQ-034 tx_enable dropped during DATA with FIFO non-empty -> the current frame completes with tx_done. No further fifo_rd_en until tx_enable rises.
REQ-035 c_STOP_BITS=2, byte 0x00 -> stop high for 8 cycles. tx_done occurs in the 8th stop cycle.
